cv32e40p_instr_fetch_queue: RTL and testbench

//  Buffers instruction-side OBI read responses between the instruction bus and the IF-stage aligner.

---
 rtl/cv32e40p_instr_fetch_queue.sv | 76 +++++++
 tb/tb_cv32e40p_instr_fetch_queue.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cv32e40p_instr_fetch_queue.sv
// cv32e40p_instr_fetch_queue: fall-through fetch FIFO with outstanding/discard tracking for OBI responses
module cv32e40p_instr_fetch_queue #(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        gnt_i,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_rdata_i,
    input  logic        resp_err_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    input  logic        fetch_ready_i,
    output logic        req_allowed_o,
    output logic        busy_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [32:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d, out_q, out_d, disc_q, disc_d;
    logic [CNT_W:0]   credit;
    logic             empty, accept, push, pop;

    // Response acceptance, fall-through output and next-state computation
    always_comb begin
        empty         = count_q == '0;
        accept        = resp_valid_i & (disc_q == '0) & ~flush_i;
        fetch_valid_o = ~flush_i & (~empty | accept);
        fetch_rdata_o = !empty ? mem_q[rptr_q][31:0] : accept ? resp_rdata_i : '0;
        fetch_err_o   = !empty ? mem_q[rptr_q][32] : accept & resp_err_i;
        pop           = ~flush_i & ~empty & fetch_ready_i;
        push          = accept & ~(empty & fetch_ready_i);
        rptr_d        = flush_i ? '0 : rptr_q + PTR_W'(pop);
        wptr_d        = flush_i ? '0 : wptr_q + PTR_W'(push);
        count_d       = flush_i ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
        out_d         = out_q + CNT_W'(gnt_i) - CNT_W'(resp_valid_i);
        disc_d        = flush_i ? out_q - CNT_W'(resp_valid_i)
                                : disc_q - CNT_W'(resp_valid_i & (disc_q != '0));
        credit        = {1'b0, count_q} + {1'b0, out_q} - {1'b0, disc_q};
        req_allowed_o = credit < (CNT_W + 1)'(DEPTH);
        busy_o        = out_q != '0;
    end

    // Control state; asynchronous reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            out_q   <= '0;
            disc_q  <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q says they are valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {resp_err_i, resp_rdata_i};
    end

`ifdef CV32E40P_ASSERT_ON
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == CNT_W'(DEPTH)));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(resp_valid_i && out_q == '0));
`endif
endmodule

// File: tb/tb_cv32e40p_instr_fetch_queue.sv
// tb_cv32e40p_instr_fetch_queue: randomized and directed checks against a queue-based reference model
module tb_cv32e40p_instr_fetch_queue;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0, gnt_i = 1'b0, resp_valid_i = 1'b0, resp_err_i = 1'b0, fetch_ready_i = 1'b0;
    logic [31:0] resp_rdata_i = '0;
    logic        fetch_valid_o, fetch_err_o, req_allowed_o, busy_o;
    logic [31:0] fetch_rdata_o;

    int n_chk = 0, n_pass = 0;
    logic [32:0] q[$];
    int m_out = 0, m_disc = 0;

    always #5 clk = ~clk;

    cv32e40p_instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .gnt_i(gnt_i),
        .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i), .resp_err_i(resp_err_i),
        .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o), .fetch_err_o(fetch_err_o),
        .fetch_ready_i(fetch_ready_i), .req_allowed_o(req_allowed_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic allowed();
        return (q.size() + m_out - m_disc) < DEPTH;
    endfunction

    task automatic step(input logic f, input logic g, input logic rv, input logic [31:0] d,
                        input logic e, input logic r);
        logic acc, ev;
        logic [32:0] w;
        @(negedge clk);
        flush_i = f; gnt_i = g; resp_valid_i = rv; resp_rdata_i = d; resp_err_i = e; fetch_ready_i = r;
        #1;
        acc = rv && m_disc == 0 && !f;
        ev  = !f && (q.size() != 0 || acc);
        w   = q.size() != 0 ? q[0] : {e, d};
        chk("valid", 32'(fetch_valid_o), 32'(ev));
        if (ev) begin
            chk("rdata", fetch_rdata_o, w[31:0]);
            chk("err", 32'(fetch_err_o), 32'(w[32]));
        end
        chk("req_allowed", 32'(req_allowed_o), 32'(allowed()));
        chk("busy", 32'(busy_o), 32'(m_out != 0));
        @(posedge clk);
        if (f) begin
            m_disc = m_out - int'(rv);
            q.delete();
        end else begin
            if (rv && m_disc > 0) m_disc--;
            else if (rv) q.push_back({e, d});
            if (ev && r) void'(q.pop_front());
        end
        m_out = m_out + int'(g) - int'(rv);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(fetch_valid_o), 32'd0);
        chk({tag, "_rdata"}, fetch_rdata_o, 32'd0);
        chk({tag, "_err"}, 32'(fetch_err_o), 32'd0);
        chk({tag, "_req"}, 32'(req_allowed_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic f, g, rv;
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("reset");
        rst_n = 1'b1;
        // fall-through of a single word
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 32'h0000_0013, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // fill with ready low, then drain in order
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 32'hAAAA_0001, 0, 0);
        step(0, 0, 1, 32'hBBBB_0002, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // flush with coincident grant: two stale responses dropped
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        step(0, 0, 1, 32'hDEAD_0001, 0, 1);
        step(0, 0, 1, 32'hDEAD_0002, 1, 1);
        step(0, 0, 1, 32'h00A0_0093, 0, 1);
        // error flag travels with its own word only
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 32'h1111_1111, 1, 0);
        step(0, 0, 1, 32'h2222_2222, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // randomized traffic with occasional flushes
        for (int i = 0; i < 3000; i++) begin
            f  = $urandom_range(15) == 0;
            g  = allowed() && m_out < 3 && $urandom_range(1) == 1;
            rv = m_out > 0 && $urandom_range(2) != 0;
            step(f, g, rv, $urandom, 1'($urandom_range(7) == 0), 1'($urandom_range(3) != 0));
        end
        while (m_out > 0) step(0, 0, 1, $urandom, 0, 1);
        while (q.size() > 0) step(0, 0, 0, 0, 0, 1);
        // asynchronous reset with one buffered word and one outstanding
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 32'h5A5A_5A5A, 0, 0);
        @(negedge clk);
        flush_i = 0; gnt_i = 0; resp_valid_i = 0; fetch_ready_i = 0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        q.delete(); m_out = 0; m_disc = 0;
        @(negedge clk) rst_n = 1'b1;
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 32'h0000_0055, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
